// File: rtl/seq_core_ctrl.sv
// Sequencer core controller: fetch / execute / memory FSM driving an external decoder,
// with program counter, saturating retire counter and a busy-cycle watchdog.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for req after reset
// S_FETCH | instr_req high, waiting for instr_rdy
// S_EXEC  | one cycle: decoder outputs for ir select the next action
// S_MEM   | mem_req high, waiting for mem_rdy
// S_DONE  | run finished (halt, end of program or watchdog); results held
module seq_core_ctrl #(
  parameter int D       = 12,
  parameter int IW      = 9,
  parameter int CW      = 16,
  parameter int MAX_CYC = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  start_addr,
  output logic          instr_req,
  input  logic          instr_rdy,
  input  logic [IW-1:0] instr,
  output logic [IW-1:0] ir,
  input  logic          is_halt,
  input  logic          is_mem,
  input  logic          is_jump,
  input  logic          is_branch,
  input  logic          zero,
  input  logic [D-1:0]  target,
  output logic          mem_req,
  input  logic          mem_rdy,
  output logic          reg_we,
  output logic          flag_we,
  output logic [D-1:0]  pc,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] icount
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CYW = $clog2(MAX_CYC + 1);
  localparam logic [CYW-1:0] WD_LAST = CYW'(MAX_CYC - 1);
  localparam logic [D-1:0]   PC_LAST = {D{1'b1}};
  localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};

  logic [2:0]     state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [CW-1:0]  icount_q, icount_d;
  logic           err_q, err_d;
  logic [CYW-1:0] cyc_q, cyc_d;
  logic           busy_c, wd_fire, retire, seq_inc, reg_we_c, flag_we_c;

  assign busy_c  = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
  // Fires on the busy cycle whose closing edge brings the counter to MAX_CYC.
  assign wd_fire = busy_c && (cyc_q == WD_LAST);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    icount_d  = icount_q;
    err_d     = err_q;
    cyc_d     = cyc_q;
    retire    = 1'b0;
    seq_inc   = 1'b0;
    reg_we_c  = 1'b0;
    flag_we_c = 1'b0;
    if (busy_c) cyc_d = cyc_q + 1'b1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          pc_d     = start_addr;
          icount_d = '0;
          err_d    = 1'b0;
          cyc_d    = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (wd_fire) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (instr_rdy) begin
          ir_d    = instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (wd_fire) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (is_halt) begin
          retire  = 1'b1;
          state_d = S_DONE;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          reg_we_c  = 1'b1;
          flag_we_c = 1'b1;
          retire    = 1'b1;
          if (is_jump || (is_branch && zero)) begin
            pc_d    = target;
            state_d = S_FETCH;
          end else begin
            seq_inc = 1'b1;
          end
        end
      end
      S_MEM: begin
        if (wd_fire) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (mem_rdy) begin
          reg_we_c = 1'b1;
          retire   = 1'b1;
          seq_inc  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Falling off the top of the address space ends the run instead of wrapping.
    if (seq_inc) begin
      if (pc_q == PC_LAST) begin
        state_d = S_DONE;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
      end
    end
    if (retire && (icount_q != CNT_MAX)) icount_d = icount_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      icount_q <= '0;
      err_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      icount_q <= icount_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
    end
  end

  assign instr_req = (state_q == S_FETCH);
  assign mem_req   = (state_q == S_MEM);
  assign reg_we    = reg_we_c;
  assign flag_we   = flag_we_c;
  assign busy      = busy_c;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign icount    = icount_q;

endmodule

// File: tb/tb_seq_core_ctrl.sv
// Bench for seq_core_ctrl: random programs laid out in memory by a path-level model,
// plus directed runs for branches, memory stalls, end of program, watchdog and reset.
module tb_seq_core_ctrl;
  localparam int D = 12;
  localparam int IW = 9;
  localparam int CW = 16;
  localparam int K_ALU = 0, K_MEM = 1, K_JMP = 2, K_BR = 3, K_HALT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, req, instr_rdy, mem_rdy;
  logic [D-1:0]  start_addr, target, pc;
  logic [IW-1:0] instr, ir;
  logic          is_halt, is_mem, is_jump, is_branch, zero;
  logic          instr_req, mem_req, reg_we, flag_we, busy, done, err;
  logic [CW-1:0] icount;

  logic          req_w, w_instr_req, w_mem_req, w_reg_we, w_flag_we, w_busy, w_done, w_err;
  logic [IW-1:0] w_ir;
  logic [D-1:0]  w_pc;
  logic [CW-1:0] w_icount;

  logic [IW-1:0] prog_mem [0:4095];
  logic [D-1:0]  tgt_mem  [0:4095];
  bit            used     [0:4095];

  // Instruction memory and decoder around the DUT
  assign instr     = prog_mem[pc];
  assign target    = tgt_mem[pc];
  assign is_halt   = ir[0];
  assign is_mem    = ir[1];
  assign is_jump   = ir[2];
  assign is_branch = ir[3];
  assign zero      = ir[8];

  seq_core_ctrl u_dut (
    .clk(clk), .reset(rst_n), .req(req), .start_addr(start_addr),
    .instr_req(instr_req), .instr_rdy(instr_rdy), .instr(instr), .ir(ir),
    .is_halt(is_halt), .is_mem(is_mem), .is_jump(is_jump), .is_branch(is_branch),
    .zero(zero), .target(target), .mem_req(mem_req), .mem_rdy(mem_rdy),
    .reg_we(reg_we), .flag_we(flag_we), .pc(pc), .busy(busy), .done(done),
    .err(err), .icount(icount)
  );

  seq_core_ctrl #(.MAX_CYC(20)) u_wd (
    .clk(clk), .reset(rst_n), .req(req_w), .start_addr(12'h0AB),
    .instr_req(w_instr_req), .instr_rdy(1'b0), .instr(9'h000), .ir(w_ir),
    .is_halt(1'b0), .is_mem(1'b0), .is_jump(1'b0), .is_branch(1'b0),
    .zero(1'b0), .target(12'h000), .mem_req(w_mem_req), .mem_rdy(1'b0),
    .reg_we(w_reg_we), .flag_we(w_flag_we), .pc(w_pc), .busy(w_busy), .done(w_done),
    .err(w_err), .icount(w_icount)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Path-level model: what the program should do, derived from the PC rules
  int g_pc, g_start;
  bit g_end;
  int exp_ret, exp_rw, exp_fw, exp_busy, exp_mreq;
  int fetch_q[$];
  int fw_q[$];
  int mw_q[$];

  task automatic new_prog(input int sa);
    for (int i = 0; i < 4096; i++) used[i] = 1'b0;
    fetch_q.delete(); fw_q.delete(); mw_q.delete();
    g_pc = sa; g_start = sa; g_end = 1'b0;
    exp_ret = 0; exp_rw = 0; exp_fw = 0; exp_busy = 0; exp_mreq = 0;
  endtask

  function automatic logic [IW-1:0] make_word(input int kind, input bit z);
    logic [IW-1:0] w;
    w = IW'($urandom);
    w[8] = z;
    case (kind)
      K_HALT:  w[0] = 1'b1;
      K_MEM:   w[1:0] = 2'b10;
      K_JMP:   w[2:0] = 3'b100;
      K_BR:    w[3:0] = 4'b1000;
      default: w[3:0] = 4'b0000;
    endcase
    return w;
  endfunction

  task automatic seq_next();
    if (g_pc == 4095) g_end = 1'b1;
    else g_pc = g_pc + 1;
  endtask

  task automatic emit(input int kind, input bit z, input int tgt, input int fw, input int mw);
    prog_mem[g_pc] = make_word(kind, z);
    tgt_mem[g_pc]  = D'(tgt);
    used[g_pc]     = 1'b1;
    fetch_q.push_back(g_pc);
    fw_q.push_back(fw);
    exp_busy += fw + 2;
    exp_ret++;
    case (kind)
      K_HALT: g_end = 1'b1;
      K_MEM: begin
        mw_q.push_back(mw);
        exp_busy += mw + 1;
        exp_mreq += mw + 1;
        exp_rw++;
        seq_next();
      end
      K_JMP: begin exp_rw++; exp_fw++; g_pc = tgt; end
      K_BR: begin
        exp_rw++; exp_fw++;
        if (z) g_pc = tgt; else seq_next();
      end
      default: begin exp_rw++; exp_fw++; seq_next(); end
    endcase
  endtask

  function automatic int fresh_addr();
    int r;
    r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 4095));
    while (used[r]) r = $urandom_range(0, 4095);
    return r;
  endfunction

  task automatic gen_random(input int len);
    int kind, tgt, pick;
    bit z, taken;
    new_prog(($urandom_range(0, 3) == 0) ? 4095 - int'($urandom_range(0, 3))
                                         : int'($urandom_range(0, 4095)));
    for (int k = 0; k < len && !g_end; k++) begin
      used[g_pc] = 1'b1;
      pick = $urandom_range(0, 9);
      if (k == len - 1 || pick == 9) kind = K_HALT;
      else if (pick < 4) kind = K_ALU;
      else if (pick < 6) kind = K_MEM;
      else if (pick == 6) kind = K_JMP;
      else kind = K_BR;
      z = 1'($urandom_range(0, 1));
      taken = (kind == K_JMP) || (kind == K_BR && z);
      tgt = taken ? fresh_addr() : int'($urandom_range(0, 4095));
      if (!taken && kind != K_HALT && g_pc != 4095 && used[g_pc + 1]) begin
        kind = K_JMP;
        tgt = fresh_addr();
      end
      emit(kind, z, tgt, $urandom_range(0, 3), $urandom_range(0, 4));
    end
  endtask

  // mode 0: normal, 1: reset at first mem_req, 2: req pulse while busy
  task automatic run_prog(input int mode);
    int fw_left, mw_left, busy_n, rw_n, fw_n, mreq_n, e;
    bit in_f, in_m, fin;
    fw_left = 0; mw_left = 0; busy_n = 0; rw_n = 0; fw_n = 0; mreq_n = 0;
    in_f = 0; in_m = 0; fin = 0;
    @(negedge clk);
    req = 1'b1; start_addr = D'(g_start);
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      req = 1'b0; start_addr = D'(g_start);
      if (done) begin
        fin = 1;
      end else begin
        if (mode == 2 && busy_n == 2) begin
          req = 1'b1; start_addr = D'(g_start ^ 'h555);
        end
        if (busy) busy_n++;
        if (mem_req) mreq_n++;
        if (instr_req) begin
          if (!in_f) begin
            in_f = 1;
            fw_left = (fw_q.size() > 0) ? fw_q.pop_front() : 0;
          end
          if (fw_left == 0) begin
            instr_rdy = 1'b1; in_f = 0;
            if (fetch_q.size() > 0) begin
              e = fetch_q.pop_front();
              chk("fetch_pc", 32'(pc), 32'(e));
            end else chk("fetch_extra", 32'(pc), 32'hFFFF_FFFF);
          end else begin
            fw_left--; instr_rdy = 1'b0;
          end
        end else instr_rdy = 1'($urandom_range(0, 1));
        if (mem_req) begin
          if (!in_m) begin
            in_m = 1;
            mw_left = (mw_q.size() > 0) ? mw_q.pop_front() : 0;
          end
          if (mw_left == 0) begin mem_rdy = 1'b1; in_m = 0; end
          else begin mw_left--; mem_rdy = 1'b0; end
        end else mem_rdy = 1'($urandom_range(0, 1));
        if (mode == 1 && mem_req) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mem_req", 32'(mem_req), 0);
          chk("rst_instr_req", 32'(instr_req), 0);
          chk("rst_reg_we", 32'(reg_we), 0);
          chk("rst_flag_we", 32'(flag_we), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_done_err", 32'({done, err}), 0);
          chk("rst_pc", 32'(pc), 0);
          chk("rst_ir", 32'(ir), 0);
          chk("rst_icount", 32'(icount), 0);
          @(negedge clk);
          rst_n = 1'b1; mem_rdy = 1'b0; instr_rdy = 1'b0;
          return;
        end
        #1;
        if (reg_we) rw_n++;
        if (flag_we) fw_n++;
      end
    end
    chk("run_finished", 32'(fin), 1);
    chk("done", 32'(done), 1);
    chk("err", 32'(err), 0);
    chk("busy_after", 32'(busy), 0);
    chk("req_lines_after", 32'({instr_req, mem_req}), 0);
    chk("final_pc", 32'(pc), 32'(g_pc));
    chk("icount", 32'(icount), 32'(exp_ret));
    chk("reg_we_pulses", 32'(rw_n), 32'(exp_rw));
    chk("flag_we_pulses", 32'(fw_n), 32'(exp_fw));
    chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
    chk("mem_req_cycles", 32'(mreq_n), 32'(exp_mreq));
    chk("fetches_left", 32'(fetch_q.size()), 0);
  endtask

  initial begin
    int n, saw;
    for (int i = 0; i < 4096; i++) begin prog_mem[i] = '0; tgt_mem[i] = '0; end
    rst_n = 1'b0; req = 1'b0; req_w = 1'b0; start_addr = '0; instr_rdy = 1'b0; mem_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pc", 32'(pc), 0);
    chk("reset_ir", 32'(ir), 0);
    chk("reset_icount", 32'(icount), 0);
    chk("reset_flags", 32'({busy, done, err, instr_req, mem_req, reg_we, flag_we}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", 32'({busy, done, instr_req}), 0);

    // straight line: 3 ALU + halt
    new_prog('h010);
    for (int i = 0; i < 3; i++) emit(K_ALU, 0, $urandom_range(0, 4095), 0, 0);
    emit(K_HALT, 0, 0, 0, 0);
    run_prog(0);

    // branch not taken, then taken
    new_prog('h020); emit(K_BR, 0, 'h005, 0, 0); emit(K_HALT, 0, 0, 0, 0); run_prog(0);
    new_prog('h020); emit(K_BR, 1, 'h005, 1, 0); emit(K_HALT, 0, 0, 0, 0); run_prog(0);

    // memory stall of 5 cycles
    new_prog('h030); emit(K_MEM, 0, 0, 0, 5); emit(K_HALT, 0, 0, 0, 0); run_prog(0);

    // end of program
    new_prog('hFFE); emit(K_ALU, 0, 0, 0, 0); emit(K_ALU, 1, 0, 2, 0); run_prog(0);

    // jump to address 0 keeps running
    new_prog('h100); emit(K_JMP, 0, 0, 0, 0); emit(K_ALU, 0, 0, 0, 0); emit(K_HALT, 0, 0, 0, 0);
    run_prog(0);

    // watchdog instance, MAX_CYC=20, fetch never answered
    @(negedge clk); req_w = 1'b1;
    @(negedge clk); req_w = 1'b0;
    n = 0; saw = 0;
    for (int c = 0; c < 100 && !w_done; c++) begin
      if (w_busy) n++;
      if (w_instr_req) saw = 1;
      @(negedge clk);
    end
    chk("wd_busy_cycles", 32'(n), 20);
    chk("wd_fetch_seen", 32'(saw), 1);
    chk("wd_done_err", 32'({w_done, w_err}), 32'h3);
    chk("wd_instr_req", 32'(w_instr_req), 0);
    chk("wd_icount", 32'(w_icount), 0);

    for (int r = 0; r < 30; r++) begin
      gen_random($urandom_range(1, 25));
      run_prog(0);
    end

    // reset during MEM, then clean restart with a req pulse while busy
    new_prog('h040); emit(K_MEM, 0, 0, 1, 10); emit(K_HALT, 0, 0, 0, 0); run_prog(1);
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'({busy, done, mem_req}), 0);
    new_prog('h050);
    for (int i = 0; i < 4; i++) emit(K_ALU, 0, 0, 1, 0);
    emit(K_HALT, 0, 0, 0, 0);
    run_prog(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_core_ctrl.md
SEQ_CORE_CTRL -- requirements
Module: seq_core_ctrl

Interface
REQ-001 Parameter D, default 12: program counter width.
REQ-002 Parameter IW, default 9: instruction width.
REQ-003 Parameter CW, default 16: retired-instruction counter width.
REQ-004 Parameter MAX_CYC, default 4095: busy-cycle watchdog limit, must be at least 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  start request.
- start_addr  in  D  first PC.
- instr_req  out  1  instruction fetch request.
- instr_rdy  in  1  instruction valid.
- instr  in  IW  fetched word.
- ir  out  IW  latched instruction, which drives the external decoder.
- is_halt, is_mem, is_jump, is_branch  in  1 each  decoder outputs for ir.
- zero  in  1  registered zero flag.
- target  in  D  jump/branch destination.
- mem_req  out  1  data-memory request.
- mem_rdy  in  1  data-memory complete.
- reg_we  out  1  register write-back strobe.
- flag_we  out  1  flag-register update strobe.
- pc  out  D  program counter.
- busy  out  1  busy.
- done  out  1  run complete.
- err  out  1  watchdog expiry.
- icount  out  CW  retired-instruction count.

Function
REQ-006 The FSM SHALL have states IDLE, FETCH, EXEC, MEM, DONE.
REQ-007 In IDLE or DONE, req=1 SHALL load pc<=start_addr, clear icount, err, done and the cycle counter, and go to FETCH.
REQ-008 FETCH: instr_req SHALL be 1; on instr_rdy=1, ir<=instr and go to EXEC; otherwise hold with no timeout other than the watchdog.
REQ-009 EXEC SHALL last exactly one cycle, with priority is_halt > is_mem > is_jump > is_branch > sequential.
REQ-010 EXEC with is_halt: go to DONE, retire with no PC change, and assert no strobes.
REQ-011 EXEC with is_mem: go to MEM with no strobes and no PC change.
REQ-012 EXEC otherwise: assert reg_we=1 and flag_we=1 for that cycle, update the PC (REQ-014), retire, and go to FETCH.
REQ-013 MEM: mem_req SHALL be 1 until mem_rdy=1; in the mem_rdy cycle assert reg_we=1 (the decoder gates it for stores), set pc<=pc+1, retire, and go to FETCH.
REQ-014 PC update: is_jump gives pc<=target; is_branch&&zero gives pc<=target; otherwise pc<=pc+1.
REQ-015 Branch not taken (is_branch&&!zero) SHALL be treated as sequential.
REQ-016 End of program: a sequential increment with pc=2**D-1 SHALL go to DONE with pc held at 2**D-1, instead of wrapping to 0; the instruction still retires.
REQ-017 Jump or branch to any target, including 0, SHALL be legal and SHALL NOT end the run.
REQ-018 Retire: icount SHALL increment by 1, saturating at 2**CW-1.
REQ-019 The watchdog cycle counter SHALL increment on every cycle outside IDLE/DONE.
REQ-020 When the cycle counter reaches MAX_CYC, the FSM SHALL set err=1 and go to DONE on the next edge from any busy state, dropping any pending instr_req/mem_req.
REQ-021 busy SHALL be 1 in FETCH, EXEC and MEM.
REQ-022 done SHALL be 1 only in DONE; done, err and icount SHALL hold until the next req or reset.
REQ-023 req while busy SHALL be ignored.
REQ-024 instr_rdy outside FETCH and mem_rdy outside MEM SHALL be ignored.
REQ-025 reg_we, flag_we, instr_req and mem_req SHALL be Moore/state-qualified as above, and never asserted in IDLE or DONE.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, pc=0, ir=0, icount=0, cycle counter=0, and drive busy, done, err, instr_req, mem_req, reg_we, flag_we to 0.
REQ-027 Reset asserted mid-FETCH or mid-MEM SHALL abort the outstanding request immediately, with no retire and no strobe.
REQ-028 After reset release, the block SHALL remain in IDLE until req=1 is sampled.

Verification (D=12, CW=16, MAX_CYC=4095 unless noted)
REQ-029 Straight-line run: req with start_addr=0x010, instr_rdy=1 every FETCH, 3 ALU ops then halt -> pc goes 0x010..0x013, icount=4, done=1 eight cycles after req, reg_we pulsed 3 times, err=0.
REQ-030 Branch: is_branch at pc=0x020, target=0x005; first with zero=0, then rerun with zero=1 -> next pc is 0x021, then 0x005.
REQ-031 Memory stall: is_mem at pc=0x030, mem_rdy delayed 5 cycles -> mem_req high for exactly 6 cycles, single reg_we in the mem_rdy cycle, next pc=0x031.
REQ-032 End of program: start_addr=0xFFE with two ALU ops -> done=1, pc=0xFFF, icount=2, no wrap to 0.
REQ-033 Watchdog: MAX_CYC=20 and instr_rdy held 0 -> err=1 and done=1 after 20 busy cycles, instr_req drops, icount=0.
REQ-034 Reset mid-MEM: reset=0 during mem_req -> all outputs 0 asynchronously; a subsequent req restarts cleanly, and req during busy is ignored.
